icache_direct: RTL and testbench
================================

ICACHE_DIRECT -- requirements
Module: icache_direct

Interface
REQ-001 The block SHALL have these ports (name direction width meaning):
- CLK  in  1  sole clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- imemREN  in  1  datapath instruction read request
- imemaddr  in  32  datapath instruction byte address
- ihit  out  1  imemload valid this cycle
- imemload  out  32  instruction word to datapath
- iwait  in  1  memory busy; data not yet valid
- iload  in  32  instruction word from memory
- iREN  out  1  read request to memory
- iaddr  out  32  word-aligned read address to memory
- hit_count  out  32  hits since reset
- miss_count  out  32  misses since reset
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-003 Organisation SHALL be direct-mapped, 16 frames, one 32-bit word per frame.
REQ-004 Each frame SHALL hold valid (1b), tag (26b), data (32b).
REQ-005 Address split SHALL be tag = imemaddr[31:6], index = imemaddr[5:2], bits [1:0] ignored.
REQ-006 Hit SHALL be combinational: imemREN & valid[index] & tag match & state==IDLE.
REQ-007 On hit: ihit=1 and imemload=data[index] in the same cycle; zero-cycle latency.
REQ-008 When ihit=0, imemload SHALL be 0.
REQ-009 FSM states SHALL be IDLE and FETCH only.
REQ-010 IDLE -> FETCH on imemREN & miss; miss_addr SHALL latch {imemaddr[31:2],2'b00} on that edge.
REQ-011 In FETCH: iREN=1, iaddr=miss_addr; in IDLE: iREN=0, iaddr=0.
REQ-012 FETCH & iwait=1: remain in FETCH, no array change.
REQ-013 FETCH & iwait=0: write iload into the frame and tag of miss_addr, set valid, return to IDLE.
REQ-014 ihit SHALL be 0 in every FETCH cycle, including the fill cycle; the hit is seen the following IDLE cycle if imemaddr still matches.
REQ-015 A fill SHALL overwrite any valid frame at that index (no write-back).
REQ-016 imemaddr or imemREN changing during FETCH SHALL NOT abort or retarget the fill; miss_addr governs.
REQ-017 imemREN=0 in IDLE: no request, no counter change.
REQ-018 hit_count SHALL increment by 1 on each rising edge where ihit=1.
REQ-019 miss_count SHALL increment by 1 on each IDLE -> FETCH transition.
REQ-020 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-021 Back-to-back misses SHALL be serviced one at a time; a new miss is detected only in IDLE.

Reset
REQ-022 When RST=1 at an edge: state=IDLE, all valid=0, miss_addr=0, hit_count=0, miss_count=0.
REQ-023 Tag and data arrays need not be reset.
REQ-024 RST during FETCH SHALL abandon the fill: no frame written, iREN=0 on the next cycle.
REQ-025 RST SHALL take priority over every other event at the same edge.

Verification
REQ-026 Cold miss: reset, imemREN=1, imemaddr=0x00000040, iwait=1 for 3 cycles then 0 with iload=0x20010005 -> iREN=1/iaddr=0x40 for 4 cycles, ihit=1 with imemload=0x20010005 next cycle, miss_count=1, hit_count=1.
REQ-027 Conflict: fill 0x00000004, then request 0x00000044 (same index 1) -> miss, refill, then 0x00000004 misses again; miss_count=3.
REQ-028 Retarget during FETCH: miss on 0x80, change imemaddr to 0x100 mid-fetch -> iaddr stays 0x80, frame 0 filled with tag of 0x80, then 0x100 misses.
REQ-029 Reset mid-fetch: RST asserted while iwait=1 -> iREN=0 next cycle, re-request of same address misses, counters 0 before the re-request.
REQ-030 Hit stream: 16 distinct filled indices re-read consecutively -> ihit=1 every cycle, hit_count advances 16, iREN stays 0.
REQ-031 Saturation: force hit_count=0xFFFFFFFE, two hits -> hit_count=0xFFFFFFFF and holds.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: 16 one-word frames with a zero-latency hit path.
// A miss stalls in FETCH until memory drops iwait, then fills the frame.
module icache_direct (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [15:0] valid_q, valid_d;
  logic [25:0] tag_q  [16];
  logic [31:0] data_q [16];
  logic [31:0] miss_addr_q, miss_addr_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [3:0]  req_idx, fill_idx;
  logic [25:0] req_tag;
  logic        fill_we;
  logic        unused_byte_bits;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign req_idx          = imemaddr[5:2];
  assign req_tag          = imemaddr[31:6];
  assign fill_idx         = miss_addr_q[5:2];
  assign unused_byte_bits = ^imemaddr[1:0];
  assign hit_count        = hit_cnt_q;
  assign miss_count       = miss_cnt_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    miss_addr_d = miss_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    ihit        = 1'b0;
    imemload    = 32'd0;
    iREN        = 1'b0;
    iaddr       = 32'd0;
    fill_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN) begin
          if (valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
            ihit      = 1'b1;
            imemload  = data_q[req_idx];
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            state_d     = FETCH;
            miss_addr_d = {imemaddr[31:2], 2'b00};
            miss_cnt_d  = sat_inc(miss_cnt_q);
          end
        end
      end
      FETCH: begin
        // The latched miss address owns the fill; live request inputs are ignored here.
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (!iwait) begin
          fill_we           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      valid_q     <= 16'd0;
      miss_addr_q <= 32'd0;
      hit_cnt_q   <= 32'd0;
      miss_cnt_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Tag/data arrays carry no reset; a reset still blocks an in-flight fill.
  always_ff @(posedge CLK) begin
    if (fill_we && !RST) begin
      tag_q[fill_idx]  <= miss_addr_q[31:6];
      data_q[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed cycle table, hit-stream/saturation sequences,
// and randomized traffic against a transaction-level cache model.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'd0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iwait = 1'b0;
  logic [31:0] iload = 32'd0;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int tests = 0;
  int fails = 0;

  icache_direct dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iwait(iwait), .iload(iload),
    .iREN(iREN), .iaddr(iaddr), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        chk;
    logic        ren;
    logic [31:0] addr;
    logic        w;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
    logic [31:0] e_hc;
    logic [31:0] e_mc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ren, input logic [31:0] addr,
                       input logic w, input logic [31:0] ld);
    RST = rst; imemREN = ren; imemaddr = addr; iwait = w; iload = ld;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  function automatic void add(input logic rst, input logic chkv, input logic ren,
                              input logic [31:0] addr, input logic w, input logic [31:0] ld,
                              input logic e_hit, input logic [31:0] e_load, input logic e_iren,
                              input logic [31:0] e_iaddr, input logic [31:0] e_hc,
                              input logic [31:0] e_mc);
    vec_t v;
    v.rst = rst; v.chk = chkv; v.ren = ren; v.addr = addr; v.w = w; v.ld = ld;
    v.e_hit = e_hit; v.e_load = e_load; v.e_iren = e_iren; v.e_iaddr = e_iaddr;
    v.e_hc = e_hc; v.e_mc = e_mc;
    tbl.push_back(v);
  endfunction

  // Simple backing store: each word address maps to a distinct pattern.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
  endfunction

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Reference cache contents, indexed by the word-address index field.
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] m_hc, m_mc;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hc = 32'd0;
    m_mc = 32'd0;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    next_cycle();
    next_cycle();
    RST = 1'b0;
    model_reset();
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, 1'b0, 32'd0);
    @(negedge CLK);
    chk("fill_miss_ihit", {31'd0, ihit}, 32'd0);
    next_cycle();
    drive(1'b0, 1'b1, a, 1'b0, d);
    @(negedge CLK);
    chk("fill_iaddr", iaddr, {a[31:2], 2'b00});
    next_cycle();
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  idx;
    logic        exp_hit;
    logic        repeat_a;
    int          nw;

    next_cycle();

    // Reset state.
    do_reset();
    drive(1'b0, 1'b0, 32'h40, 1'b0, 32'd0);
    @(negedge CLK);
    chk("rst_iren", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_hc", hit_count, 32'd0);
    chk("rst_mc", miss_count, 32'd0);
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_load", imemload, 32'd0);

    // Directed cycle table: cold miss, conflict, retarget, reset mid-fetch.
    //  rst chk ren addr     w  ld            hit load          iren iaddr    hc  mc
    add(1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 0);
    add(0, 1, 1, 32'h40,  1, 32'h0,        0, 32'h0,        0, 32'h0,   0, 0);
    add(0, 1, 1, 32'h40,  1, 32'h0,        0, 32'h0,        1, 32'h40,  0, 1);
    add(0, 1, 1, 32'h40,  1, 32'h0,        0, 32'h0,        1, 32'h40,  0, 1);
    add(0, 1, 1, 32'h40,  1, 32'h0,        0, 32'h0,        1, 32'h40,  0, 1);
    add(0, 1, 1, 32'h40,  0, 32'h20010005, 0, 32'h0,        1, 32'h40,  0, 1);
    add(0, 1, 1, 32'h40,  0, 32'h0,        1, 32'h20010005, 0, 32'h0,   0, 1);
    add(0, 1, 0, 32'h40,  0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 1);
    add(1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 0);
    add(0, 1, 1, 32'h4,   0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 0);
    add(0, 1, 1, 32'h4,   0, 32'h11111111, 0, 32'h0,        1, 32'h4,   0, 1);
    add(0, 1, 1, 32'h4,   0, 32'h0,        1, 32'h11111111, 0, 32'h0,   0, 1);
    add(0, 1, 1, 32'h44,  0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 1);
    add(0, 1, 1, 32'h44,  0, 32'h22222222, 0, 32'h0,        1, 32'h44,  1, 2);
    add(0, 1, 1, 32'h44,  0, 32'h0,        1, 32'h22222222, 0, 32'h0,   1, 2);
    add(0, 1, 1, 32'h4,   0, 32'h0,        0, 32'h0,        0, 32'h0,   2, 2);
    add(0, 1, 1, 32'h4,   0, 32'h33333333, 0, 32'h0,        1, 32'h4,   2, 3);
    add(0, 1, 1, 32'h4,   0, 32'h0,        1, 32'h33333333, 0, 32'h0,   2, 3);
    add(0, 1, 0, 32'h4,   0, 32'h0,        0, 32'h0,        0, 32'h0,   3, 3);
    add(1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 0);
    add(0, 1, 1, 32'h80,  1, 32'h0,        0, 32'h0,        0, 32'h0,   0, 0);
    add(0, 1, 1, 32'h100, 1, 32'h0,        0, 32'h0,        1, 32'h80,  0, 1);
    add(0, 1, 0, 32'h100, 0, 32'h44444444, 0, 32'h0,        1, 32'h80,  0, 1);
    add(0, 1, 1, 32'h80,  0, 32'h0,        1, 32'h44444444, 0, 32'h0,   0, 1);
    add(0, 1, 1, 32'h100, 0, 32'h0,        0, 32'h0,        0, 32'h0,   1, 1);
    add(0, 1, 1, 32'h100, 0, 32'h55555555, 0, 32'h0,        1, 32'h100, 1, 2);
    add(0, 1, 1, 32'h100, 0, 32'h0,        1, 32'h55555555, 0, 32'h0,   1, 2);
    add(1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 0);
    add(0, 1, 1, 32'h200, 1, 32'h0,        0, 32'h0,        0, 32'h0,   0, 0);
    add(1, 1, 1, 32'h200, 1, 32'h0,        0, 32'h0,        1, 32'h200, 0, 1);
    add(0, 1, 0, 32'h200, 0, 32'h66666666, 0, 32'h0,        0, 32'h0,   0, 0);
    add(0, 1, 1, 32'h200, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 0);
    add(0, 1, 1, 32'h200, 0, 32'h77777777, 0, 32'h0,        1, 32'h200, 0, 1);
    add(0, 1, 1, 32'h200, 0, 32'h0,        1, 32'h77777777, 0, 32'h0,   0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ren, tbl[i].addr, tbl[i].w, tbl[i].ld);
      @(negedge CLK);
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_ihit", i), {31'd0, ihit}, {31'd0, tbl[i].e_hit});
        chk($sformatf("tbl%0d_load", i), imemload, tbl[i].e_load);
        chk($sformatf("tbl%0d_iren", i), {31'd0, iREN}, {31'd0, tbl[i].e_iren});
        chk($sformatf("tbl%0d_iaddr", i), iaddr, tbl[i].e_iaddr);
        chk($sformatf("tbl%0d_hc", i), hit_count, tbl[i].e_hc);
        chk($sformatf("tbl%0d_mc", i), miss_count, tbl[i].e_mc);
      end
      next_cycle();
    end

    // Hit stream across all 16 frames.
    do_reset();
    for (int i = 0; i < 16; i++) fill(32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i));
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge CLK);
    chk("stream_mc", miss_count, 32'd16);
    chk("stream_hc0", hit_count, 32'd0);
    next_cycle();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 32'h1000 + 32'(i * 4), 1'b0, 32'd0);
      @(negedge CLK);
      chk($sformatf("stream%0d_ihit", i), {31'd0, ihit}, 32'd1);
      chk($sformatf("stream%0d_load", i), imemload, 32'hA000_0000 + 32'(i));
      chk($sformatf("stream%0d_iren", i), {31'd0, iREN}, 32'd0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge CLK);
    chk("stream_hc16", hit_count, 32'd16);
    next_cycle();

    // Hit counter saturation.
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt_q;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 32'h1000, 1'b0, 32'd0);
      @(negedge CLK);
      chk($sformatf("sat%0d_ihit", i), {31'd0, ihit}, 32'd1);
      next_cycle();
    end
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge CLK);
    chk("sat_hc", hit_count, 32'hFFFF_FFFF);
    next_cycle();
    drive(1'b0, 1'b1, 32'h1000, 1'b0, 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge CLK);
    chk("sat_hold", hit_count, 32'hFFFF_FFFF);
    next_cycle();

    // Randomized traffic against the reference model.
    do_reset();
    repeat_a = 1'b0;
    a = 32'd0;
    for (int t = 0; t < 200; t++) begin
      if (!repeat_a && $urandom_range(0, 4) == 0) begin
        drive(1'b0, 1'b0, $urandom, 1'b0, $urandom);
        @(negedge CLK);
        chk("rnd_idle_ihit", {31'd0, ihit}, 32'd0);
        chk("rnd_idle_iren", {31'd0, iREN}, 32'd0);
        chk("rnd_idle_hc", hit_count, m_hc);
        chk("rnd_idle_mc", miss_count, m_mc);
        next_cycle();
        continue;
      end
      if (!repeat_a)
        a = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom)};
      repeat_a = 1'b0;
      idx = a[5:2];
      exp_hit = m_valid[idx] && (m_tag[idx] == a[31:6]);
      drive(1'b0, 1'b1, a, 1'b0, 32'd0);
      @(negedge CLK);
      chk("rnd_ihit", {31'd0, ihit}, {31'd0, exp_hit});
      chk("rnd_load", imemload, exp_hit ? m_data[idx] : 32'd0);
      chk("rnd_iren", {31'd0, iREN}, 32'd0);
      chk("rnd_hc", hit_count, m_hc);
      chk("rnd_mc", miss_count, m_mc);
      next_cycle();
      if (exp_hit) begin
        m_hc = sat1(m_hc);
      end else begin
        m_mc = sat1(m_mc);
        nw = $urandom_range(0, 3);
        for (int k = 0; k <= nw; k++) begin
          drive(1'b0, 1'($urandom), $urandom, (k < nw), (k < nw) ? $urandom : memw(a));
          @(negedge CLK);
          chk("rnd_fetch_iren", {31'd0, iREN}, 32'd1);
          chk("rnd_fetch_iaddr", iaddr, {a[31:2], 2'b00});
          chk("rnd_fetch_ihit", {31'd0, ihit}, 32'd0);
          next_cycle();
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a[31:6];
        m_data[idx]  = memw(a);
        repeat_a = ($urandom_range(0, 1) == 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
